// File: rtl/muldiv_sched.sv
// muldiv_sched: shares one multi-cycle mul/div unit between the two harts.
// Each hart has one request slot. Slots are issued round-robin, one
// operation is in flight at a time, and the result is held in a buffer
// until the writeback port takes it.
module muldiv_sched #(
  parameter int XLEN       = 32,
  parameter int HART_ID_W  = 1,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [HART_ID_W-1:0]  req_hart,
  input  logic [2:0]            req_op,
  input  logic [XLEN-1:0]       req_a,
  input  logic [XLEN-1:0]       req_b,
  input  logic [REG_ADDR_W-1:0] req_rd,
  output logic                  req_accept,
  output logic [1:0]            hart_stall,
  output logic                  muldiv_start,
  output logic [2:0]            muldiv_op,
  output logic [XLEN-1:0]       muldiv_a,
  output logic [XLEN-1:0]       muldiv_b,
  output logic [HART_ID_W-1:0]  muldiv_hart_id,
  output logic [REG_ADDR_W-1:0] muldiv_rd,
  input  logic                  muldiv_busy,
  input  logic                  muldiv_done,
  input  logic [XLEN-1:0]       muldiv_result,
  input  logic [HART_ID_W-1:0]  muldiv_done_hart_id,
  input  logic [REG_ADDR_W-1:0] muldiv_done_rd,
  output logic                  wb_valid,
  output logic [HART_ID_W-1:0]  wb_hart,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  input  logic                  wb_ready,
  output logic                  protocol_err
);

  typedef enum logic [1:0] {SLOT_EMPTY, SLOT_PENDING, SLOT_INFLIGHT} slot_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_HOLD} state_t;

  state_t                r_state, w_state_next;
  logic                  r_rr_ptr;
  logic                  r_start;
  logic [2:0]            r_mdu_op;
  logic [XLEN-1:0]       r_mdu_a, r_mdu_b;
  logic [HART_ID_W-1:0]  r_mdu_hart;
  logic [REG_ADDR_W-1:0] r_mdu_rd;
  logic                  r_wb_valid;
  logic [HART_ID_W-1:0]  r_wb_hart;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic [XLEN-1:0]       r_wb_data;
  logic                  r_err;

  logic [1:0]            w_empty, w_pending, w_accept_h, w_issue_h, w_free_h;
  logic [2:0]            w_slot_op [2];
  logic [XLEN-1:0]       w_slot_a  [2];
  logic [XLEN-1:0]       w_slot_b  [2];
  logic [REG_ADDR_W-1:0] w_slot_rd [2];
  logic                  w_win, w_issue, w_wb_fire, w_done_ok;

  // A freed slot only becomes EMPTY after the handshake edge, so a new
  // request for that hart is accepted one cycle later at the earliest.
  assign req_accept = req_valid && w_empty[req_hart];
  // Round-robin: the pointer hart wins if it has work, else the other one.
  assign w_win      = w_pending[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
  assign w_issue    = (r_state == ST_IDLE) && !muldiv_busy && (|w_pending);
  assign w_wb_fire  = (r_state == ST_HOLD) && wb_ready;
  assign w_done_ok  = (r_state == ST_WAIT) && (muldiv_done_hart_id == r_mdu_hart)
                      && (muldiv_done_rd == r_mdu_rd);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      slot_t                 r_st;
      logic [2:0]            r_op;
      logic [XLEN-1:0]       r_a, r_b;
      logic [REG_ADDR_W-1:0] r_rd;

      assign w_empty[gi]    = (r_st == SLOT_EMPTY);
      assign w_pending[gi]  = (r_st == SLOT_PENDING);
      assign hart_stall[gi] = (r_st != SLOT_EMPTY);
      assign w_accept_h[gi] = req_accept && (req_hart == HART_ID_W'(gi));
      assign w_issue_h[gi]  = w_issue && (w_win == 1'(gi));
      assign w_free_h[gi]   = w_wb_fire && (r_mdu_hart == HART_ID_W'(gi));
      assign w_slot_op[gi]  = r_op;
      assign w_slot_a[gi]   = r_a;
      assign w_slot_b[gi]   = r_b;
      assign w_slot_rd[gi]  = r_rd;

      // Slot lifecycle: EMPTY -> PENDING -> INFLIGHT -> EMPTY, payload on accept
      always_ff @(posedge clk) begin
        if (rst) begin
          r_st <= SLOT_EMPTY;
          r_op <= '0;
          r_a  <= '0;
          r_b  <= '0;
          r_rd <= '0;
        end else if (w_accept_h[gi]) begin
          r_st <= SLOT_PENDING;
          r_op <= req_op;
          r_a  <= req_a;
          r_b  <= req_b;
          r_rd <= req_rd;
        end else if (w_issue_h[gi]) begin
          r_st <= SLOT_INFLIGHT;
        end else if (w_free_h[gi]) begin
          r_st <= SLOT_EMPTY;
        end
      end
    end
  endgenerate

  // Unit FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Unit FSM next-state: one op at a time, result buffer must drain before reissue
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_issue) w_state_next = ST_ISSUE;
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT:  if (muldiv_done) w_state_next = ST_HOLD;
      ST_HOLD:  if (wb_ready) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Start pulse/operands, result buffer capture and sticky protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= 1'b0;
      r_start    <= 1'b0;
      r_mdu_op   <= '0;
      r_mdu_a    <= '0;
      r_mdu_b    <= '0;
      r_mdu_hart <= '0;
      r_mdu_rd   <= '0;
      r_wb_valid <= 1'b0;
      r_wb_hart  <= '0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_start <= w_issue;
      if (w_issue) begin
        r_mdu_op   <= w_slot_op[w_win];
        r_mdu_a    <= w_slot_a[w_win];
        r_mdu_b    <= w_slot_b[w_win];
        r_mdu_rd   <= w_slot_rd[w_win];
        r_mdu_hart <= HART_ID_W'(w_win);
        r_rr_ptr   <= ~w_win;
      end
      // A done that does not match the in-flight op is still captured
      if ((r_state == ST_WAIT) && muldiv_done) begin
        r_wb_valid <= 1'b1;
        r_wb_hart  <= muldiv_done_hart_id;
        r_wb_rd    <= muldiv_done_rd;
        r_wb_data  <= muldiv_result;
      end else if (w_wb_fire) begin
        r_wb_valid <= 1'b0;
      end
      if (muldiv_done && !w_done_ok) r_err <= 1'b1;
    end
  end

  assign muldiv_start   = r_start;
  assign muldiv_op      = r_mdu_op;
  assign muldiv_a       = r_mdu_a;
  assign muldiv_b       = r_mdu_b;
  assign muldiv_hart_id = r_mdu_hart;
  assign muldiv_rd      = r_mdu_rd;
  assign wb_valid       = r_wb_valid;
  assign wb_hart        = r_wb_hart;
  assign wb_rd          = r_wb_rd;
  assign wb_data        = r_wb_data;
  assign protocol_err   = r_err;

endmodule
